pipe_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage core.

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_ctrl_perf.sv | 20 ++
 rtl/pipe_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_X0 = '0;

  // Controller states; encodings kept fixed so existing waveforms and
  // debug scripts keep decoding them the same way.
  localparam logic [1:0] PCTL_RUN   = 2'd0;
  localparam logic [1:0] PCTL_DRAIN = 2'd1;
  localparam logic [1:0] PCTL_INV   = 2'd2;

  // One bundle for every per-cycle control pin driven by the controller.
  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_stall;
    logic mem_stall;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
    logic pc_redirect;
    logic icache_inv;
  } ctrl_t;

  // True when a source operand is really read and names the given register.
  function automatic logic src_hit(input logic [REG_W-1:0] rs,
                                   input logic             used,
                                   input logic [REG_W-1:0] waddr);
    return used && (rs == waddr);
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating event counter used for the stall-cycle performance statistic.
module pipe_ctrl_perf #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles; once all-ones the value sticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/sequencing controller for the 5-stage core: drives the
// pipeline-register stall/flush pins, the PC redirect, the fence.i drain
// sequence and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned FENCE_INC = 4
) (
  input  logic              clk,
  input  logic              rst,
  // ID stage
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_is_fence,
  input  logic [DATA_W-1:0] fence_pc,
  // EX stage
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_gprs_waddr,
  input  logic              ex_busy,
  input  logic              ex_branch_taken,
  input  logic [DATA_W-1:0] ex_branch_target,
  // MEM / WB stages
  input  logic              mem_valid,
  input  logic              wb_valid,
  input  logic              mem_wait,
  input  logic              mem_trap,
  input  logic [DATA_W-1:0] trap_vector,
  // Pipeline controls
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              flush_mem,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              icache_inv,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [DATA_W-1:0] FENCE_OFS = DATA_W'(FENCE_INC);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] fence_q;
  logic              fence_take;
  logic              load_use;
  logic              pipe_empty;
  ctrl_t             ctrl_raw;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] rpc_raw;

  assign load_use = id_valid && ex_valid && ex_is_load &&
                    (ex_gprs_waddr != REG_X0) &&
                    (src_hit(id_rs1, id_rs1_used, ex_gprs_waddr) ||
                     src_hit(id_rs2, id_rs2_used, ex_gprs_waddr));

  assign pipe_empty = !(ex_valid || mem_valid || wb_valid);

  // Per-cycle priority resolution and next-state selection.
  always_comb begin
    ctrl_raw   = '0;
    rpc_raw    = '0;
    state_nxt  = state;
    fence_take = 1'b0;

    // The invalidate pulse belongs to INV regardless of what else happens.
    if (state == PCTL_INV) ctrl_raw.icache_inv = 1'b1;

    if (mem_trap) begin
      ctrl_raw.flush_id    = 1'b1;
      ctrl_raw.flush_ex    = 1'b1;
      ctrl_raw.flush_mem   = 1'b1;
      ctrl_raw.pc_redirect = 1'b1;
      rpc_raw              = trap_vector;
      state_nxt            = PCTL_RUN;
    end else if (state == PCTL_INV) begin
      ctrl_raw.flush_id    = 1'b1;
      ctrl_raw.pc_redirect = 1'b1;
      rpc_raw              = fence_q + FENCE_OFS;
      state_nxt            = PCTL_RUN;
    end else if (state != PCTL_RUN && state != PCTL_DRAIN) begin
      state_nxt = PCTL_RUN;
    end else if (mem_wait) begin
      ctrl_raw.if_stall  = 1'b1;
      ctrl_raw.id_stall  = 1'b1;
      ctrl_raw.ex_stall  = 1'b1;
      ctrl_raw.mem_stall = 1'b1;
    end else if (ex_busy) begin
      ctrl_raw.if_stall  = 1'b1;
      ctrl_raw.id_stall  = 1'b1;
      ctrl_raw.ex_stall  = 1'b1;
      ctrl_raw.flush_mem = 1'b1;
    end else if (ex_valid && ex_branch_taken) begin
      ctrl_raw.flush_id    = 1'b1;
      ctrl_raw.flush_ex    = 1'b1;
      ctrl_raw.pc_redirect = 1'b1;
      rpc_raw              = ex_branch_target;
      state_nxt            = PCTL_RUN;
    end else if (state == PCTL_DRAIN) begin
      // A load-use hit during DRAIN asks for the same stall/bubble, so the
      // drain behaviour covers it; leave once nothing is left below ID.
      ctrl_raw.if_stall = 1'b1;
      ctrl_raw.id_stall = 1'b1;
      ctrl_raw.flush_ex = 1'b1;
      if (pipe_empty) state_nxt = PCTL_INV;
    end else if (load_use) begin
      ctrl_raw.if_stall = 1'b1;
      ctrl_raw.id_stall = 1'b1;
      ctrl_raw.flush_ex = 1'b1;
    end else if (id_valid && id_is_fence) begin
      ctrl_raw.if_stall = 1'b1;
      ctrl_raw.id_stall = 1'b1;
      ctrl_raw.flush_ex = 1'b1;
      fence_take        = 1'b1;
      state_nxt         = PCTL_DRAIN;
    end
  end

  // Controls are silenced for as long as reset is held.
  always_comb begin
    ctrl = '0;
    if (rst) ctrl = ctrl_raw;
  end

  assign if_stall    = ctrl.if_stall;
  assign id_stall    = ctrl.id_stall;
  assign ex_stall    = ctrl.ex_stall;
  assign mem_stall   = ctrl.mem_stall;
  assign flush_id    = ctrl.flush_id;
  assign flush_ex    = ctrl.flush_ex;
  assign flush_mem   = ctrl.flush_mem;
  assign pc_redirect = ctrl.pc_redirect;
  assign icache_inv  = ctrl.icache_inv;
  assign redirect_pc = ctrl.pc_redirect ? rpc_raw : '0;

  // Sequencing state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PCTL_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the fence.i pc when the drain sequence starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fence_q <= '0;
    end else if (fence_take) begin
      fence_q <= fence_pc;
    end
  end

  pipe_ctrl_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.if_stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used;
  logic        id_is_fence;
  logic [31:0] fence_pc;
  logic        ex_valid, ex_is_load;
  logic [4:0]  ex_gprs_waddr;
  logic        ex_busy, ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        mem_valid, wb_valid, mem_wait, mem_trap;
  logic [31:0] trap_vector;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        flush_id, flush_ex, flush_mem;
  logic        pc_redirect, icache_inv;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  // {if,id,ex,mem stall, flush_id,flush_ex,flush_mem, pc_redirect, icache_inv}
  logic [8:0] ctrl;
  assign ctrl = {if_stall, id_stall, ex_stall, mem_stall,
                 flush_id, flush_ex, flush_mem, pc_redirect, icache_inv};

  localparam logic [8:0] C_NONE  = 9'b0000_000_00;
  localparam logic [8:0] C_LU    = 9'b1100_010_00;
  localparam logic [8:0] C_BR    = 9'b0000_110_10;
  localparam logic [8:0] C_WAIT  = 9'b1111_000_00;
  localparam logic [8:0] C_BUSY  = 9'b1110_001_00;
  localparam logic [8:0] C_TRAP  = 9'b0000_111_10;
  localparam logic [8:0] C_INV   = 9'b0000_100_11;

  pipe_ctrl #(
    .CNT_W     (32),
    .FENCE_INC (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rs1_used      (id_rs1_used),
    .id_rs2_used      (id_rs2_used),
    .id_is_fence      (id_is_fence),
    .fence_pc         (fence_pc),
    .ex_valid         (ex_valid),
    .ex_is_load       (ex_is_load),
    .ex_gprs_waddr    (ex_gprs_waddr),
    .ex_busy          (ex_busy),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .mem_valid        (mem_valid),
    .wb_valid         (wb_valid),
    .mem_wait         (mem_wait),
    .mem_trap         (mem_trap),
    .trap_vector      (trap_vector),
    .if_stall         (if_stall),
    .id_stall         (id_stall),
    .ex_stall         (ex_stall),
    .mem_stall        (mem_stall),
    .flush_id         (flush_id),
    .flush_ex         (flush_ex),
    .flush_mem        (flush_mem),
    .pc_redirect      (pc_redirect),
    .redirect_pc      (redirect_pc),
    .icache_inv       (icache_inv),
    .stall_cycles     (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_is_fence = 0; fence_pc = 0;
    ex_valid = 0; ex_is_load = 0; ex_gprs_waddr = 0; ex_busy = 0;
    ex_branch_taken = 0; ex_branch_target = 0;
    mem_valid = 0; wb_valid = 0; mem_wait = 0; mem_trap = 0; trap_vector = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    id_valid = 1; id_rs1 = 5'd5; id_rs1_used = 1;
    ex_valid = 1; ex_is_load = 1; ex_gprs_waddr = 5'd5;
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    mem_trap = 1; trap_vector = 32'h1234_5678;
    @(negedge clk);
    check("reset_ctrl", 64'(ctrl), 64'(C_NONE));
    check("reset_rpc", 64'(redirect_pc), 64'h0);
    check("reset_cnt", 64'(stall_cycles), 64'h0);
    next_cycle();
    clear_inputs();
    rst = 1;

    @(negedge clk);
    check("idle_ctrl", 64'(ctrl), 64'(C_NONE));
    next_cycle();

    // 1: load-use bubble, then EX holds the nop
    set_load_use();
    @(negedge clk);
    check("lu_ctrl", 64'(ctrl), 64'(C_LU));
    check("lu_cnt_before", 64'(stall_cycles), 64'h0);
    next_cycle();
    ex_valid = 0; ex_is_load = 0;
    @(negedge clk);
    check("lu_after_ctrl", 64'(ctrl), 64'(C_NONE));
    check("lu_cnt_after", 64'(stall_cycles), 64'h1);
    next_cycle();

    // 2: x0 destination, unused source, rs2 match
    set_load_use(); ex_gprs_waddr = 5'd0; id_rs1 = 5'd0;
    @(negedge clk);
    check("lu_x0", 64'(ctrl), 64'(C_NONE));
    next_cycle();
    set_load_use(); id_rs1_used = 0;
    @(negedge clk);
    check("lu_unused", 64'(ctrl), 64'(C_NONE));
    next_cycle();
    set_load_use(); id_rs1 = 5'd7; id_rs2 = 5'd5; id_rs2_used = 1;
    @(negedge clk);
    check("lu_rs2", 64'(ctrl), 64'(C_LU));
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("lu_rs2_cnt", 64'(stall_cycles), 64'h2);
    next_cycle();

    // 3: branch beats load-use
    set_load_use(); ex_branch_taken = 1; ex_branch_target = 32'h8000_0100;
    @(negedge clk);
    check("br_ctrl", 64'(ctrl), 64'(C_BR));
    check("br_rpc", 64'(redirect_pc), 64'h8000_0100);
    next_cycle();
    clear_inputs();

    // 4: mem_wait holds everything for 3 cycles, branch redirects on the 4th
    ex_valid = 1; ex_branch_taken = 1; ex_branch_target = 32'h8000_0100;
    mem_valid = 1; mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_ctrl", 64'(ctrl), 64'(C_WAIT));
      check("wait_rpc", 64'(redirect_pc), 64'h0);
      next_cycle();
    end
    mem_wait = 0;
    @(negedge clk);
    check("wait_br_ctrl", 64'(ctrl), 64'(C_BR));
    check("wait_br_rpc", 64'(redirect_pc), 64'h8000_0100);
    check("wait_cnt", 64'(stall_cycles), 64'h5);
    next_cycle();
    clear_inputs();

    // ex_busy with a pending branch: busy wins
    ex_valid = 1; ex_busy = 1; ex_branch_taken = 1;
    @(negedge clk);
    check("busy_ctrl", 64'(ctrl), 64'(C_BUSY));
    next_cycle();
    clear_inputs();

    // mem_trap beats mem_wait
    mem_valid = 1; mem_wait = 1; mem_trap = 1; trap_vector = 32'h0000_0200;
    @(negedge clk);
    check("trap_ctrl", 64'(ctrl), 64'(C_TRAP));
    check("trap_rpc", 64'(redirect_pc), 64'h0000_0200);
    check("trap_cnt", 64'(stall_cycles), 64'h6);
    next_cycle();
    clear_inputs();

    // 5: fence.i drain and invalidate
    id_valid = 1; id_is_fence = 1; fence_pc = 32'h8000_0040;
    ex_valid = 1; mem_valid = 1; wb_valid = 1;
    @(negedge clk);
    check("fence_accept", 64'(ctrl), 64'(C_LU));
    next_cycle();
    fence_pc = 32'hDEAD_0000; ex_valid = 0;
    @(negedge clk);
    check("drain1", 64'(ctrl), 64'(C_LU));
    next_cycle();
    mem_valid = 0; wb_valid = 0;
    @(negedge clk);
    check("drain2", 64'(ctrl), 64'(C_LU));
    next_cycle();
    @(negedge clk);
    check("inv_ctrl", 64'(ctrl), 64'(C_INV));
    check("inv_rpc", 64'(redirect_pc), 64'h8000_0044);
    check("inv_cnt", 64'(stall_cycles), 64'h9);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("post_inv", 64'(ctrl), 64'(C_NONE));
    check("post_inv_cnt", 64'(stall_cycles), 64'h9);
    next_cycle();

    // 6: reset asserted mid-DRAIN
    id_valid = 1; id_is_fence = 1; fence_pc = 32'h8000_0080; ex_valid = 1;
    @(negedge clk);
    check("f2_accept", 64'(ctrl), 64'(C_LU));
    next_cycle();
    @(negedge clk);
    check("f2_drain", 64'(ctrl), 64'(C_LU));
    check("f2_cnt", 64'(stall_cycles), 64'hA);
    rst = 0;
    #1;
    check("rst_ctrl", 64'(ctrl), 64'(C_NONE));
    check("rst_cnt", 64'(stall_cycles), 64'h0);
    next_cycle();
    rst = 1;
    id_is_fence = 0; mem_valid = 1;
    @(negedge clk);
    check("rst_run_ctrl", 64'(ctrl), 64'(C_NONE));
    check("rst_run_cnt", 64'(stall_cycles), 64'h0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("rst_idle", 64'(ctrl), 64'(C_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
